// File: rtl/lzw_backward_pkg.sv
// Shared definitions for the LZW backward reverse sequencer: state encoding,
// string-length limits and the default credit threshold.
package lzw_backward_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } lzw_state_e;

    localparam int unsigned LEN_W             = 5;
    localparam int unsigned MAX_STR_LEN       = 31;
    localparam int unsigned OCC_LIMIT_DEFAULT = 768;

    // Strings of two or more bytes need the byte-reverse block to flip them.
    function automatic logic needs_reverse(input logic [LEN_W-1:0] len);
        return (len >= 5'd2);
    endfunction

    function automatic logic [1:0] err_events(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/lzw_backward_reverse_ctrl_if.sv
// Stream bus between the dictionary walker, this sequencer and the byte-reverse block.
interface lzw_backward_reverse_ctrl_if;
    import lzw_backward_pkg::*;

    logic [LEN_W-1:0] I_str_len;
    logic             I_str_len_en;
    logic [7:0]       I_str_data;
    logic             I_str_data_en;
    logic             I_out_data_en;
    logic             O_ready;
    logic [7:0]       O_dictionary_recv_data;
    logic             O_dictionary_recv_data_en;
    logic             O_reverse_byte_flag;
    logic [LEN_W-1:0] O_reverse_byte_num;
    logic             O_reverse_byte_num_wren;

    modport slave (
        input  I_str_len, I_str_len_en, I_str_data, I_str_data_en, I_out_data_en,
        output O_ready, O_dictionary_recv_data, O_dictionary_recv_data_en,
               O_reverse_byte_flag, O_reverse_byte_num, O_reverse_byte_num_wren
    );

    modport master (
        output I_str_len, I_str_len_en, I_str_data, I_str_data_en, I_out_data_en,
        input  O_ready, O_dictionary_recv_data, O_dictionary_recv_data_en,
               O_reverse_byte_flag, O_reverse_byte_num, O_reverse_byte_num_wren
    );

endinterface

// File: rtl/lzw_occ_credit.sv
// Bytes-in-flight counter toward the byte-reverse FIFOs and the registered
// ready decision that keeps room for one maximum-length string.
module lzw_occ_credit
    import lzw_backward_pkg::*;
#(
    parameter int unsigned OCC_LIMIT = OCC_LIMIT_DEFAULT,
    parameter int unsigned OCC_W     = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic idle,
    output logic ready,
    output logic underflow
);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ready_q, ready_d;
    logic             under_s;

    // Next occupancy with saturation at both ends; ready follows the current count.
    always_comb begin
        occ_d   = occ_q;
        under_s = 1'b0;
        if (inc && !dec) begin
            if (occ_q != {OCC_W{1'b1}}) begin
                occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
            end else begin
                occ_d = occ_q;
            end
        end else if (dec && !inc) begin
            if (occ_q == {OCC_W{1'b0}}) begin
                under_s = 1'b1;
            end else begin
                occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            occ_d = occ_q;
        end
        ready_d = idle &&
                  (({1'b0, occ_q} + (OCC_W+1)'(MAX_STR_LEN)) <= (OCC_W+1)'(OCC_LIMIT));
    end

    // Occupancy and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= {OCC_W{1'b0}};
            ready_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            ready_q <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign underflow = under_s;

endmodule

// File: rtl/lzw_backward_reverse_ctrl.sv
// Sequencer feeding lzw_backward_byte_reverse: one header then its bytes,
// with reverse-count writes, credit backpressure and per-stream statistics.
module lzw_backward_reverse_ctrl
    import lzw_backward_pkg::*;
#(
    parameter int unsigned OCC_LIMIT = OCC_LIMIT_DEFAULT,
    parameter int unsigned OCC_W     = 11,
    parameter int unsigned STAT_W    = 32
) (
    input  logic                            I_sys_clk,
    input  logic                            I_sys_rst_n,
    input  logic                            I_state_clr,
    lzw_backward_reverse_ctrl_if.slave      bus,
    output logic [STAT_W-1:0]               O_str_cnt,
    output logic [STAT_W-1:0]               O_byte_cnt,
    output logic [STAT_W-1:0]               O_rev_str_cnt,
    output logic [STAT_W-1:0]               O_err_cnt,
    output logic                            O_err
);

    lzw_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d, len_q, len_d, num_q, num_d;
    logic             rev_q, rev_d, first_q, first_d;
    logic [7:0]       data_q, data_d;
    logic             den_q, den_d, flag_q, flag_d, wren_q, wren_d;
    logic [STAT_W-1:0] str_q, str_d, byte_q, byte_d, revc_q, revc_d, errc_q, errc_d;
    logic             err_q, err_d;
    logic             fwd_s, perr_s, hdr_ok_s, ready_s, under_s;
    logic [1:0]       err_inc_s;

    lzw_occ_credit #(.OCC_LIMIT(OCC_LIMIT), .OCC_W(OCC_W)) u_occ (
        .clk       (I_sys_clk),
        .rst_n     (I_sys_rst_n),
        .inc       (fwd_s),
        .dec       (bus.I_out_data_en),
        .idle      (state_q == ST_IDLE),
        .ready     (ready_s),
        .underflow (under_s)
    );

    // Header/byte protocol, forwarding decision and next output values.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        len_d    = len_q;
        rev_d    = rev_q;
        first_d  = first_q;
        fwd_s    = 1'b0;
        perr_s   = 1'b0;
        hdr_ok_s = 1'b0;
        wren_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.I_str_len_en) begin
                    if (bus.I_str_len == 5'd0) begin
                        perr_s = 1'b1;
                    end else begin
                        // Accepted even without credit, but the overrun is recorded.
                        hdr_ok_s = 1'b1;
                        perr_s   = !ready_s;
                        state_d  = ST_STREAM;
                        rem_d    = bus.I_str_len;
                        len_d    = bus.I_str_len;
                        rev_d    = needs_reverse(bus.I_str_len);
                        first_d  = needs_reverse(bus.I_str_len);
                        fwd_s    = bus.I_str_data_en;
                    end
                end else if (bus.I_str_data_en) begin
                    perr_s = 1'b1;
                end else begin
                    perr_s = 1'b0;
                end
            end
            ST_STREAM: begin
                if (bus.I_str_len_en) begin
                    perr_s  = 1'b1;
                    state_d = ST_IDLE;
                    first_d = 1'b0;
                end else begin
                    fwd_s = bus.I_str_data_en;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (fwd_s) begin
            wren_d  = first_d;
            first_d = 1'b0;
            if (rem_d == 5'd1) begin
                state_d = ST_IDLE;
            end else begin
                state_d = state_d;
            end
            rem_d = rem_d - 5'd1;
        end else begin
            wren_d = 1'b0;
        end
        den_d  = fwd_s;
        data_d = fwd_s ? bus.I_str_data : data_q;
        num_d  = wren_d ? len_d : num_q;
        flag_d = (fwd_s || (state_d == ST_STREAM)) ? rev_d : 1'b0;

        err_inc_s = err_events(perr_s, under_s);
        if (I_state_clr) begin
            str_d  = {STAT_W{1'b0}};
            byte_d = {STAT_W{1'b0}};
            revc_d = {STAT_W{1'b0}};
            errc_d = {STAT_W{1'b0}};
            err_d  = 1'b0;
        end else begin
            str_d  = str_q  + {{(STAT_W-1){1'b0}}, hdr_ok_s};
            byte_d = byte_q + {{(STAT_W-1){1'b0}}, fwd_s};
            revc_d = revc_q + {{(STAT_W-1){1'b0}}, hdr_ok_s && rev_d};
            errc_d = errc_q + {{(STAT_W-2){1'b0}}, err_inc_s};
            err_d  = err_q || (err_inc_s != 2'd0);
        end
    end

    // FSM, registered outputs and statistics.
    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= 5'd0;
            len_q   <= 5'd0;
            rev_q   <= 1'b0;
            first_q <= 1'b0;
            data_q  <= 8'd0;
            den_q   <= 1'b0;
            flag_q  <= 1'b0;
            num_q   <= 5'd0;
            wren_q  <= 1'b0;
            str_q   <= {STAT_W{1'b0}};
            byte_q  <= {STAT_W{1'b0}};
            revc_q  <= {STAT_W{1'b0}};
            errc_q  <= {STAT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            rev_q   <= rev_d;
            first_q <= first_d;
            data_q  <= data_d;
            den_q   <= den_d;
            flag_q  <= flag_d;
            num_q   <= num_d;
            wren_q  <= wren_d;
            str_q   <= str_d;
            byte_q  <= byte_d;
            revc_q  <= revc_d;
            errc_q  <= errc_d;
            err_q   <= err_d;
        end
    end

    assign bus.O_ready                   = ready_s;
    assign bus.O_dictionary_recv_data    = data_q;
    assign bus.O_dictionary_recv_data_en = den_q;
    assign bus.O_reverse_byte_flag       = flag_q;
    assign bus.O_reverse_byte_num        = num_q;
    assign bus.O_reverse_byte_num_wren   = wren_q;
    assign O_str_cnt     = str_q;
    assign O_byte_cnt    = byte_q;
    assign O_rev_str_cnt = revc_q;
    assign O_err_cnt     = errc_q;
    assign O_err         = err_q;

endmodule

// File: tb/tb_lzw_backward_reverse_ctrl.sv
// Directed and randomized bench for lzw_backward_reverse_ctrl with a
// string-level reference model of forwarding, credits and statistics.
module tb_lzw_backward_reverse_ctrl;

    localparam int OCC_LIMIT = 768;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] str_cnt, byte_cnt, rev_cnt, err_cnt;
    logic        err;

    lzw_backward_reverse_ctrl_if bus();

    lzw_backward_reverse_ctrl dut (
        .I_sys_clk     (clk),
        .I_sys_rst_n   (rst_n),
        .I_state_clr   (clr),
        .bus           (bus),
        .O_str_cnt     (str_cnt),
        .O_byte_cnt    (byte_cnt),
        .O_rev_str_cnt (rev_cnt),
        .O_err_cnt     (err_cnt),
        .O_err         (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: string in progress, bytes left, and bytes in flight.
    bit        m_busy, m_rev, m_first;
    int        m_rem, m_len, m_occ;
    bit        e_ready, e_den, e_flag, e_wren, e_err;
    bit [7:0]  e_data;
    bit [4:0]  e_num;
    bit [31:0] e_str, e_byte, e_rev, e_errc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_rev = 0; m_first = 0; m_rem = 0; m_len = 0; m_occ = 0;
        e_ready = 1; e_den = 0; e_flag = 0; e_wren = 0; e_err = 0;
        e_data = 8'h00; e_num = 5'd0;
        e_str = 0; e_byte = 0; e_rev = 0; e_errc = 0;
    endtask

    task automatic model(input bit hdr, input bit [4:0] len, input bit byt,
                         input bit [7:0] d, input bit drain, input bit sclr);
        bit fwd, perr, wren, under, nready, nbusy;
        fwd = 0; perr = 0; wren = 0; under = 0;
        nready = !m_busy && (m_occ + 31 <= OCC_LIMIT);
        nbusy  = m_busy;
        if (!m_busy) begin
            if (hdr) begin
                if (len == 5'd0) begin
                    perr = 1;
                end else begin
                    if (!e_ready) perr = 1;
                    e_str++;
                    if (len >= 5'd2) e_rev++;
                    m_len = int'(len); m_rem = int'(len);
                    m_rev = (len >= 5'd2); m_first = m_rev;
                    nbusy = 1; fwd = byt;
                end
            end else if (byt) begin
                perr = 1;
            end
        end else begin
            if (hdr) begin
                perr = 1; nbusy = 0;
            end else begin
                fwd = byt;
            end
        end
        if (fwd) begin
            e_data = d; wren = m_first; m_first = 0;
            m_rem--;
            if (m_rem == 0) nbusy = 0;
            e_byte++;
        end
        e_den  = fwd;
        e_wren = wren;
        if (wren) e_num = m_len[4:0];
        e_flag = (fwd || nbusy) ? m_rev : 1'b0;
        if (fwd && !drain) m_occ++;
        else if (drain && !fwd) begin
            if (m_occ == 0) under = 1;
            else m_occ--;
        end
        e_errc += 32'(perr) + 32'(under);
        if (perr || under) e_err = 1;
        if (sclr) begin
            e_str = 0; e_byte = 0; e_rev = 0; e_errc = 0; e_err = 0;
        end
        m_busy  = nbusy;
        e_ready = nready;
    endtask

    task automatic compare_all();
        check("data_en", bus.O_dictionary_recv_data_en, e_den);
        if (e_den) check("data", bus.O_dictionary_recv_data, e_data);
        check("flag", bus.O_reverse_byte_flag, e_flag);
        check("num_wren", bus.O_reverse_byte_num_wren, e_wren);
        if (e_wren) check("num", bus.O_reverse_byte_num, e_num);
        check("ready", bus.O_ready, e_ready);
        check("str_cnt", str_cnt, e_str);
        check("byte_cnt", byte_cnt, e_byte);
        check("rev_str_cnt", rev_cnt, e_rev);
        check("err_cnt", err_cnt, e_errc);
        check("err", err, e_err);
    endtask

    task automatic step(input bit hdr, input bit [4:0] len, input bit byt,
                        input bit [7:0] d, input bit drain, input bit sclr);
        @(negedge clk);
        bus.I_str_len_en  = hdr;
        bus.I_str_len     = len;
        bus.I_str_data_en = byt;
        bus.I_str_data    = d;
        bus.I_out_data_en = drain;
        clr               = sclr;
        model(hdr, len, byt, d, drain, sclr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 0, 8'h00, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, bus.O_dictionary_recv_data, 32'h0);
        check({tag, "_data_en"}, bus.O_dictionary_recv_data_en, 32'h0);
        check({tag, "_flag"}, bus.O_reverse_byte_flag, 32'h0);
        check({tag, "_num"}, bus.O_reverse_byte_num, 32'h0);
        check({tag, "_wren"}, bus.O_reverse_byte_num_wren, 32'h0);
        check({tag, "_ready"}, bus.O_ready, 32'h1);
        check({tag, "_str"}, str_cnt, 32'h0);
        check({tag, "_err"}, err, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.I_str_len_en = 0; bus.I_str_data_en = 0; bus.I_out_data_en = 0;
        clr = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        bus.I_str_len = 5'd0; bus.I_str_len_en = 0;
        bus.I_str_data = 8'h00; bus.I_str_data_en = 0; bus.I_out_data_en = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1;
        idle(2);

        // Single-byte string: no reversal, no count write.
        step(1, 5'd1, 1, 8'h41, 0, 0);
        idle(2);
        check("tp1_str_cnt", str_cnt, 32'd1);
        check("tp1_rev_cnt", rev_cnt, 32'd0);

        // Four-byte string arriving backwards.
        step(1, 5'd4, 1, 8'h44, 0, 0);
        step(0, 5'd0, 1, 8'h43, 0, 0);
        step(0, 5'd0, 1, 8'h42, 0, 0);
        step(0, 5'd0, 1, 8'h41, 0, 0);
        idle(2);
        check("tp2_rev_cnt", rev_cnt, 32'd1);

        // Zero-length header, then a clear.
        step(1, 5'd0, 0, 8'h00, 0, 0);
        check("tp3_err_cnt", err_cnt, 32'd1);
        check("tp3_err", err, 32'd1);
        step(0, 5'd0, 0, 8'h00, 0, 1);
        check("tp3_clr_err", err, 32'd0);
        idle(1);

        // Header interrupting a five-byte string after two bytes.
        step(1, 5'd5, 0, 8'h00, 0, 0);
        step(0, 5'd0, 1, 8'h15, 0, 0);
        step(0, 5'd0, 1, 8'h14, 0, 0);
        step(1, 5'd3, 0, 8'h00, 0, 0);
        step(0, 5'd0, 1, 8'h99, 0, 0);
        idle(2);
        check("tp4_err_cnt", err_cnt, 32'd2);

        // Randomized traffic including protocol errors and drains.
        for (int i = 0; i < 500; i++) begin
            bit       h, b, dr, c;
            bit [4:0] l;
            h  = ($urandom % 6) == 0;
            l  = (($urandom % 10) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            b  = ($urandom % 3) != 0;
            dr = ($urandom % 2) == 0;
            c  = ($urandom % 60) == 0;
            step(h, l, b, 8'($urandom), dr, c);
        end

        // Fill 740 bytes without draining, then drain 40.
        do_reset();
        idle(1);
        for (int s = 0; s < 24; s++) begin
            int l;
            l = (s < 23) ? 31 : 27;
            step(1, 5'(l), 1, 8'($urandom), 0, 0);
            for (int k = 1; k < l; k++) step(0, 5'd0, 1, 8'($urandom), 0, 0);
            idle(2);
        end
        check("fill_ready_low", bus.O_ready, 32'd0);
        check("fill_byte_cnt", byte_cnt, 32'd740);
        for (int k = 0; k < 40; k++) step(0, 5'd0, 0, 8'h00, 1, 0);
        idle(2);
        check("drain_ready_high", bus.O_ready, 32'd1);
        for (int k = 0; k < 700; k++) step(0, 5'd0, 0, 8'h00, 1, 0);

        // Asynchronous reset in the middle of an eight-byte string.
        step(1, 5'd8, 1, 8'h88, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 5'd0, 1, 8'h87 - 8'(k), 0, 0);
        #2;
        rst_n = 0;
        bus.I_str_len_en = 0; bus.I_str_data_en = 0; bus.I_out_data_en = 0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        idle(1);
        step(1, 5'd2, 1, 8'h22, 0, 0);
        step(0, 5'd0, 1, 8'h11, 0, 0);
        idle(2);
        check("post_rst_rev_cnt", rev_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
